lsf_input_sequencer: RTL and testbench

//  Sits directly upstream of the LSF spy-buffer wrapper and frames the hit-extraction output into LSF windows.

---
 rtl/lsf_input_sequencer.sv | 146 ++++++++++++++
 tb/tb_lsf_input_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsf_input_sequencer.sv
// Frames hit-extraction output into LSF windows: one ROI word, up to MAX_HITS hits, then an EOF pulse
// carrying the forwarded-hit count. Enforces the hit cap, a collect timeout and a post-EOF holdoff.
module lsf_input_sequencer #(
  parameter int SLC_W       = 32,
  parameter int HIT_W       = 40,
  parameter int MAX_HITS    = 32,
  parameter int WIN_TIMEOUT = 256,
  parameter int HOLDOFF     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SLC_W-1:0] i_slc,
  input  logic             i_slc_valid,
  input  logic [HIT_W-1:0] i_hit,
  input  logic             i_hit_valid,
  input  logic             i_window_done,
  output logic [SLC_W-1:0] o_roi,
  output logic             o_roi_we,
  output logic [HIT_W-1:0] o_mdt_hit,
  output logic             o_mdt_hit_we,
  output logic             o_eof,
  output logic [9:0]       o_histogram_accumulation_count,
  output logic             o_busy,
  output logic             o_slc_drop,
  output logic [15:0]      o_hit_drop_cnt
);
  localparam int TMO_W = $clog2(WIN_TIMEOUT);
  localparam int HLD_W = $clog2(HOLDOFF + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WIN_TIMEOUT - 1);
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLDOFF);
  localparam logic [9:0]       HIT_CAP  = 10'(MAX_HITS);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EOF, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [9:0]       hit_cnt_q, hit_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic [SLC_W-1:0] roi_q, roi_d;
  logic             roi_we_q, roi_we_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             hit_we_q, hit_we_d;
  logic             eof_q, eof_d;
  logic [9:0]       acc_q, acc_d;
  logic             slc_drop_q, slc_drop_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             hit_drop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      hit_cnt_q  <= '0;
      tmo_q      <= '0;
      hold_q     <= '0;
      roi_q      <= '0;
      roi_we_q   <= 1'b0;
      hit_q      <= '0;
      hit_we_q   <= 1'b0;
      eof_q      <= 1'b0;
      acc_q      <= '0;
      slc_drop_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hit_cnt_q  <= hit_cnt_d;
      tmo_q      <= tmo_d;
      hold_q     <= hold_d;
      roi_q      <= roi_d;
      roi_we_q   <= roi_we_d;
      hit_q      <= hit_d;
      hit_we_q   <= hit_we_d;
      eof_q      <= eof_d;
      acc_q      <= acc_d;
      slc_drop_q <= slc_drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hit_cnt_d  = hit_cnt_q;
    tmo_d      = tmo_q;
    hold_d     = hold_q;
    roi_d      = roi_q;
    roi_we_d   = 1'b0;
    hit_d      = hit_q;
    hit_we_d   = 1'b0;
    eof_d      = 1'b0;
    acc_d      = acc_q;
    slc_drop_d = 1'b0;
    hit_drop   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // a hit arriving alongside the SLC precedes the window, so it is dropped
        hit_drop = i_hit_valid;
        if (i_slc_valid) begin
          roi_d     = i_slc;
          roi_we_d  = 1'b1;
          hit_cnt_d = '0;
          tmo_d     = '0;
          state_d   = S_COLLECT;
        end
      end
      S_COLLECT: begin
        slc_drop_d = i_slc_valid;
        tmo_d      = tmo_q + TMO_W'(1);
        if (i_hit_valid) begin
          if (hit_cnt_q < HIT_CAP) begin
            hit_d     = i_hit;
            hit_we_d  = 1'b1;
            hit_cnt_d = hit_cnt_q + 10'd1;
          end else begin
            hit_drop = 1'b1;
          end
        end
        if (i_window_done || tmo_q == TMO_LAST) state_d = S_EOF;
      end
      S_EOF: begin
        slc_drop_d = i_slc_valid;
        hit_drop   = i_hit_valid;
        eof_d      = 1'b1;
        acc_d      = hit_cnt_q;
        hold_d     = '0;
        state_d    = S_HOLD;
      end
      default: begin
        slc_drop_d = i_slc_valid;
        hit_drop   = i_hit_valid;
        if (hold_q == HLD_LAST) state_d = S_IDLE;
        else                    hold_d  = hold_q + HLD_W'(1);
      end
    endcase
    drop_cnt_d = drop_cnt_q;
    if (hit_drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  assign o_roi                          = roi_q;
  assign o_roi_we                       = roi_we_q;
  assign o_mdt_hit                      = hit_q;
  assign o_mdt_hit_we                   = hit_we_q;
  assign o_eof                          = eof_q;
  assign o_histogram_accumulation_count = acc_q;
  assign o_busy                         = (state_q != S_IDLE);
  assign o_slc_drop                     = slc_drop_q;
  assign o_hit_drop_cnt                 = drop_cnt_q;
endmodule

// File: tb/tb_lsf_input_sequencer.sv
// Bench for lsf_input_sequencer: timestamp-based window model checked every cycle, plus directed
// scenarios with hand-computed cycle/count expectations and a randomized back-to-back run.
module tb_lsf_input_sequencer;
  localparam int SLC_W = 32, HIT_W = 40, MAX_HITS = 32, WT = 256, HOLDOFF = 8;
  localparam longint NEVER = 64'h7fff_ffff_ffff;

  logic clock = 1'b0, reset = 1'b1;
  logic [SLC_W-1:0] i_slc = '0;
  logic             i_slc_valid = 1'b0;
  logic [HIT_W-1:0] i_hit = '0;
  logic             i_hit_valid = 1'b0, i_window_done = 1'b0;
  logic [SLC_W-1:0] o_roi;
  logic             o_roi_we, o_mdt_hit_we, o_eof, o_busy, o_slc_drop;
  logic [HIT_W-1:0] o_mdt_hit;
  logic [9:0]       o_histogram_accumulation_count;
  logic [15:0]      o_hit_drop_cnt;

  always #5 clock = ~clock;

  lsf_input_sequencer #(.SLC_W(SLC_W), .HIT_W(HIT_W), .MAX_HITS(MAX_HITS),
                        .WIN_TIMEOUT(WT), .HOLDOFF(HOLDOFF)) dut (
    .clock(clock), .reset(reset), .i_slc(i_slc), .i_slc_valid(i_slc_valid),
    .i_hit(i_hit), .i_hit_valid(i_hit_valid), .i_window_done(i_window_done),
    .o_roi(o_roi), .o_roi_we(o_roi_we), .o_mdt_hit(o_mdt_hit), .o_mdt_hit_we(o_mdt_hit_we),
    .o_eof(o_eof), .o_histogram_accumulation_count(o_histogram_accumulation_count),
    .o_busy(o_busy), .o_slc_drop(o_slc_drop), .o_hit_drop_cnt(o_hit_drop_cnt));

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a window is described by its accept cycle and close cycle; the phase at any
  // cycle follows from those timestamps alone.
  longint mc = 0, m_acc = 0, m_close = NEVER;
  bit     started = 0, m_active = 0;
  int     m_n = 0, m_mode = 0, e_drop = 0;
  logic [SLC_W-1:0] e_roi = '0;
  logic [HIT_W-1:0] e_hit = '0;
  logic [9:0]       e_cnt = '0;
  logic e_roi_we = 0, e_hit_we = 0, e_eof = 0, e_busy = 0, e_slc_drop = 0;

  function automatic int mode_at(input longint c); // 0 idle, 1 collect, 2 eof, 3 hold
    if (!m_active)                      return 0;
    if (c <= m_close)                   return 1;
    if (c == m_close + 1)               return 2;
    if (c <= m_close + 2 + HOLDOFF)     return 3;
    return 0;
  endfunction

  always @(posedge clock) begin
    m_mode = mode_at(mc);
    e_roi_we = 0; e_hit_we = 0; e_eof = 0; e_slc_drop = 0;
    if (reset) begin
      started = 1; m_active = 0; e_roi = '0; e_hit = '0; e_cnt = '0; e_drop = 0;
    end else begin
      if (m_mode != 0) e_slc_drop = i_slc_valid;
      if (m_mode == 0 && i_slc_valid) begin
        m_active = 1; m_acc = mc; m_close = NEVER; m_n = 0; e_roi = i_slc; e_roi_we = 1;
      end
      if (i_hit_valid) begin
        if (m_mode == 1 && m_n < MAX_HITS) begin
          e_hit = i_hit; e_hit_we = 1; m_n++;
        end else if (e_drop < 65535) e_drop++;
      end
      if (m_mode == 1 && (i_window_done || (mc - m_acc - 1) == WT - 1)) m_close = mc;
      if (m_mode == 2) begin e_eof = 1; e_cnt = 10'(m_n); end
    end
    mc++;
    e_busy = (mode_at(mc) != 0);
  end

  // Monitors feed the directed literal checks; per-cycle compare against the model.
  longint eof_cyc = -1, roi_cyc = -1, sd_cyc = -1, idle_cyc = -1;
  int n_eof = 0, n_hwe = 0;
  logic [9:0] eof_val = '0;
  bit prev_busy = 0;
  always @(negedge clock) if (started) begin
    chk("roi_we", o_roi_we, e_roi_we);
    chk("roi", o_roi, e_roi);
    chk("hit_we", o_mdt_hit_we, e_hit_we);
    chk("hit", o_mdt_hit, e_hit);
    chk("eof", o_eof, e_eof);
    chk("count", o_histogram_accumulation_count, e_cnt);
    chk("busy", o_busy, e_busy);
    chk("slc_drop", o_slc_drop, e_slc_drop);
    chk("drop_cnt", o_hit_drop_cnt, e_drop);
    if (o_eof === 1'b1) begin eof_cyc = mc; eof_val = o_histogram_accumulation_count; n_eof++; end
    if (o_mdt_hit_we === 1'b1) n_hwe++;
    if (o_roi_we === 1'b1) roi_cyc = mc;
    if (o_slc_drop === 1'b1) sd_cyc = mc;
    if (prev_busy && o_busy === 1'b0) idle_cyc = mc;
    prev_busy = (o_busy === 1'b1);
  end

  task automatic step(); @(posedge clock); #1; endtask
  task automatic idle_in();
    i_slc_valid = 0; i_hit_valid = 0; i_window_done = 0;
  endtask
  task automatic do_reset();
    idle_in(); reset = 1; step(); step(); reset = 0;
  endtask
  task automatic send_slc(input logic [SLC_W-1:0] v);
    i_slc = v; i_slc_valid = 1; step(); i_slc_valid = 0;
  endtask
  task automatic send_hits(input int n, input bit done_last);
    for (int i = 0; i < n; i++) begin
      i_hit = HIT_W'(64'h100 + i); i_hit_valid = 1; i_window_done = done_last && (i == n - 1);
      step();
    end
    idle_in();
  endtask
  task automatic wait_cycles(input int n); repeat (n) step(); endtask

  longint t0;
  int b_hwe, b_eof;
  initial begin
    do_reset();
    chk("reset roi_we", o_roi_we, 0);
    chk("reset eof", o_eof, 0);
    chk("reset busy", o_busy, 0);
    chk("reset drop_cnt", o_hit_drop_cnt, 0);
    chk("reset count", o_histogram_accumulation_count, 0);

    // nominal: SLC t0, hits t2..t6 with window_done at t6
    b_hwe = n_hwe; t0 = mc;
    send_slc(32'hA5A5_0001); step();
    send_hits(5, 1);
    wait_cycles(20);
    chk("nom roi_we cycle", roi_cyc, t0 + 1);
    chk("nom hit_we count", n_hwe - b_hwe, 5);
    chk("nom eof cycle", eof_cyc, t0 + 8);
    chk("nom eof count", eof_val, 5);
    chk("nom model count", e_cnt, 5);
    chk("nom busy low cycle", idle_cyc, t0 + 8 + HOLDOFF + 1);

    // cap: 40 hits, 32 forwarded, 8 dropped
    do_reset(); b_hwe = n_hwe; b_eof = n_eof;
    send_slc(32'h0000_0C47);
    send_hits(40, 0);
    i_window_done = 1; step(); idle_in();
    wait_cycles(20);
    chk("cap hit_we count", n_hwe - b_hwe, 32);
    chk("cap drop_cnt", o_hit_drop_cnt, 8);
    chk("cap model drop", e_drop, 8);
    chk("cap eof count", eof_val, 32);
    chk("cap eof number", n_eof - b_eof, 1);

    // timeout: no window_done
    do_reset(); b_eof = n_eof; t0 = mc;
    send_slc(32'h7100_0003);
    send_hits(3, 0);
    for (int k = 0; k < WT + 40 && n_eof == b_eof; k++) step();
    chk("tmo eof seen", n_eof - b_eof, 1);
    chk("tmo eof cycle", eof_cyc, t0 + 1 + WT + 1);
    chk("tmo eof count", eof_val, 3);
    wait_cycles(HOLDOFF + 4);

    // collisions
    do_reset(); t0 = mc;
    send_slc(32'hC011_0001);
    send_hits(2, 0);
    send_slc(32'hC011_0002);
    i_window_done = 1; step(); idle_in();
    wait_cycles(16);
    chk("col slc_drop cycle", sd_cyc, t0 + 4);
    chk("col eof count", eof_val, 2);
    chk("col roi kept", o_roi, 32'hC011_0001);
    t0 = mc;
    i_slc = 32'hC011_0003; i_slc_valid = 1; i_hit = 40'h55; i_hit_valid = 1;
    step(); idle_in(); step();
    chk("col idle roi_we cycle", roi_cyc, t0 + 1);
    chk("col idle drop_cnt", o_hit_drop_cnt, 1);
    i_window_done = 1; step(); idle_in(); wait_cycles(16);

    // reset mid-collect
    do_reset();
    send_slc(32'hDEAD_0005);
    send_hits(4, 0);
    reset = 1; step(); reset = 0;
    chk("mid-rst roi", o_roi, 0);
    chk("mid-rst hit_we", o_mdt_hit_we, 0);
    chk("mid-rst hit", o_mdt_hit, 0);
    chk("mid-rst busy", o_busy, 0);
    chk("mid-rst count", o_histogram_accumulation_count, 0);
    b_eof = n_eof;
    wait_cycles(20);
    chk("mid-rst no eof", n_eof - b_eof, 0);
    send_slc(32'hDEAD_0006);
    send_hits(2, 1);
    wait_cycles(20);
    chk("post-rst eof count", eof_val, 2);

    // back-to-back random windows
    do_reset(); b_eof = n_eof;
    for (int w = 0; w < 100; w++) begin
      int nh, sent;
      for (int k = 0; k < 100 && mode_at(mc) != 0; k++) begin
        i_hit_valid = ($urandom_range(0, 7) == 0); i_hit = HIT_W'($urandom); step();
      end
      chk("b2b idle wait", mode_at(mc), 0);
      i_hit_valid = 0;
      send_slc(SLC_W'($urandom));
      nh = $urandom_range(0, 40); sent = 0;
      while (sent < nh) begin
        i_hit_valid = ($urandom_range(0, 3) != 0);
        i_hit = {HIT_W'($urandom), 8'(w)};
        i_slc = SLC_W'($urandom); i_slc_valid = ($urandom_range(0, 15) == 0);
        if (i_hit_valid) sent++;
        step();
      end
      i_slc_valid = 0; i_hit_valid = 0;
      i_window_done = 1; step(); idle_in();
    end
    wait_cycles(HOLDOFF + 6);
    chk("b2b eof number", n_eof - b_eof, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
